// File: rtl/pipelined_adder_n_if.sv
// Handshake and data bundle for pipelined_adder_n: operand side (in_*, a, b, sub)
// and result side (out_*, sum, cout, overflow).
interface pipelined_adder_n_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, sum, cout, overflow
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, sum, cout, overflow
   );
endinterface

// File: rtl/pipelined_adder_n.sv
// WIDTH-bit add/subtract split into STAGES chunks with a registered carry between stages,
// under a single global stall. Define ADDER_SAT_EN to saturate sum on signed overflow.
module pipelined_adder_n #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input logic                clk,
   input logic                rst_n,
   pipelined_adder_n_if.slave bus
);
   localparam int CHUNK = WIDTH / STAGES;

   logic             advance;
   logic             ovf_out;
   logic [WIDTH-1:0] opa  [STAGES];
   logic [WIDTH-1:0] opb  [STAGES];
   logic [WIDTH-1:0] sums [STAGES];
   logic             carry[STAGES];
   logic             vld  [STAGES];

`ifdef ADDER_SAT_EN
   // A wrapped result with its MSB set means the true value was positive.
   function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] s, input logic ovf);
      if (!ovf) return s;
      return s[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
   endfunction
`endif

   assign advance      = !vld[STAGES-1] || bus.out_ready;
   assign bus.in_ready = advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] a_src, b_src, s_src, s_nxt, s_load;
      logic             c_src, v_src;
      logic [CHUNK:0]   part;
      logic [WIDTH-1:0] a_q, b_q, s_q;
      logic             c_q, v_q;
      logic             ops_unused;

      if (k == 0) begin : g_first
         assign a_src = bus.a;
         assign b_src = bus.sub ? ~bus.b : bus.b;
         assign s_src = '0;
         assign c_src = bus.sub;
         assign v_src = bus.in_valid;
      end else begin : g_rest
         assign a_src = opa[k-1];
         assign b_src = opb[k-1];
         assign s_src = sums[k-1];
         assign c_src = carry[k-1];
         assign v_src = vld[k-1];
      end

      assign part = {1'b0, a_src[k*CHUNK +: CHUNK]} + {1'b0, b_src[k*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, c_src};

      always_comb begin
         s_nxt                    = s_src;
         s_nxt[k*CHUNK +: CHUNK]  = part[CHUNK-1:0];
      end

      if (k == STAGES - 1) begin : g_last
         logic ovf_nxt, ovf_q;
         // Carry into the MSB is recovered as a^b^sum at that bit.
         assign ovf_nxt = a_src[WIDTH-1] ^ b_src[WIDTH-1] ^ part[CHUNK-1] ^ part[CHUNK];
`ifdef ADDER_SAT_EN
         assign s_load  = saturate(s_nxt, ovf_nxt);
`else
         assign s_load  = s_nxt;
`endif
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)       ovf_q <= 1'b0;
            else if (advance) ovf_q <= ovf_nxt;
         end
         assign ovf_out = ovf_q;
      end else begin : g_mid
         assign s_load = s_nxt;
      end

      // Stage register boundary
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
            c_q <= 1'b0;
         end else if (advance) begin
            v_q <= v_src;
            a_q <= a_src;
            b_q <= b_src;
            s_q <= s_load;
            c_q <= part[CHUNK];
         end
      end

      assign opa[k]   = a_q;
      assign opb[k]   = b_q;
      assign sums[k]  = s_q;
      assign carry[k] = c_q;
      assign vld[k]   = v_q;

      // Operand chunks already consumed are dead; synthesis trims them.
      assign ops_unused = ^{opa[k], opb[k]};
   end

   assign bus.out_valid = vld[STAGES-1];
   assign bus.sum       = sums[STAGES-1];
   assign bus.cout      = carry[STAGES-1];
   assign bus.overflow  = ovf_out;
endmodule

// File: tb/tb_pipelined_adder_n.sv
// Scoreboard bench for pipelined_adder_n (WIDTH=16, STAGES=4); honours ADDER_SAT_EN.
module tb_pipelined_adder_n;
   localparam int WIDTH  = 16;
   localparam int STAGES = 4;

   typedef struct packed {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic in_xfer;
   exp_t nxt_exp;
   exp_t sb[$];

   pipelined_adder_n_if #(.WIDTH(WIDTH)) bus ();

   pipelined_adder_n #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic sv);
      logic [16:0] full;
      exp_t        e;
      full   = sv ? ({1'b0, av} + {1'b0, ~bv} + 17'd1) : ({1'b0, av} + {1'b0, bv});
      e.sum  = full[15:0];
      e.cout = full[16];
      e.ovf  = sv ? ((av[15] != bv[15]) && (e.sum[15] != av[15]))
                  : ((av[15] == bv[15]) && (e.sum[15] != av[15]));
`ifdef ADDER_SAT_EN
      if (e.ovf) e.sum = av[15] ? 16'h8000 : 16'h7FFF;
`endif
      return e;
   endfunction

   // Called just after a falling edge with inputs already driven.
   task automatic cycle();
      exp_t e;
      #1;
      in_xfer = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_out", {31'd0, bus.out_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("sum",      {16'd0, bus.sum},      {16'd0, e.sum});
            chk("cout",     {31'd0, bus.cout},     {31'd0, e.cout});
            chk("overflow", {31'd0, bus.overflow}, {31'd0, e.ovf});
         end
      end
      if (in_xfer) sb.push_back(nxt_exp);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic put(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                      input logic [15:0] es, input logic ec, input logic eo);
      bus.in_valid = 1'b1;
      bus.a        = av;
      bus.b        = bv;
      bus.sub      = sv;
      nxt_exp      = '{es, ec, eo};
   endtask

   task automatic drain();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int n = 0; n < 40 && sb.size() > 0; n++) cycle();
      chk("drain_empty", sb.size(), 32'd0);
      cycle();
      cycle();
   endtask

   int          idx;
   int          stall_left;
   logic        first_seen;
   logic [15:0] ra, rb;
   logic        rs;

   initial begin
      checks        = 0;
      errors        = 0;
      in_xfer       = 1'b0;
      nxt_exp       = '0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_sum",       {16'd0, bus.sum},       32'd0);
      chk("rst_cout",      {31'd0, bus.cout},      32'd0);
      chk("rst_overflow",  {31'd0, bus.overflow},  32'd0);
      chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Carry across chunk boundaries, with latency check
      put(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
      cycle();
      bus.in_valid = 1'b0;
      for (int j = 1; j < STAGES; j++) begin
         chk("latency_early", {31'd0, bus.out_valid}, 32'd0);
         cycle();
      end
      chk("latency_due", {31'd0, bus.out_valid}, 32'd1);
      drain();

      // Directed add/sub corner cases, back to back
      put(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      cycle();
`ifdef ADDER_SAT_EN
      put(16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
`else
      put(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
`endif
      cycle();
      put(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      cycle();
`ifdef ADDER_SAT_EN
      put(16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
      put(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif
      cycle();
      drain();

      // Eight back-to-back inputs with a 3-cycle downstream stall at the first output
      idx        = 1;
      stall_left = 0;
      first_seen = 1'b0;
      for (int n = 0; n < 60 && (idx <= 8 || sb.size() > 0); n++) begin
         bus.in_valid = (idx <= 8);
         bus.a        = 16'(idx);
         bus.b        = 16'(idx);
         bus.sub      = 1'b0;
         nxt_exp      = '{16'(2 * idx), 1'b0, 1'b0};
         if (bus.out_valid && !first_seen) begin
            first_seen = 1'b1;
            stall_left = 3;
         end
         bus.out_ready = (stall_left == 0);
         if (stall_left > 0) begin
            #1;
            chk("stall_in_ready",  {31'd0, bus.in_ready},  32'd0);
            chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall_hold_sum",  {16'd0, bus.sum},       32'd2);
            stall_left--;
         end
         cycle();
         if (in_xfer) idx++;
      end
      chk("b2b_all_accepted", idx, 32'd9);
      drain();

      // Random traffic with random back-pressure
      for (int n = 0; n < 40; n++) begin
         ra            = 16'($urandom);
         rb            = 16'($urandom);
         rs            = 1'($urandom_range(0, 1));
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.a         = ra;
         bus.b         = rb;
         bus.sub       = rs;
         nxt_exp       = model(ra, rb, rs);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      drain();

      // Reset with three transactions in flight
      for (int i = 1; i <= 3; i++) begin
         put(16'(i * 16'h0101), 16'h0010, 1'b0, 16'(i * 16'h0101 + 16'h0010), 1'b0, 1'b0);
         cycle();
      end
      bus.in_valid = 1'b0;
      cycle();
      chk("pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("midrst_sum",       {16'd0, bus.sum},       32'd0);
      chk("midrst_in_ready",  {31'd0, bus.in_ready},  32'd1);
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j <= STAGES; j++) begin
         chk("post_rst_no_stale", {31'd0, bus.out_valid}, 32'd0);
         cycle();
      end
      put(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
      cycle();
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipelined_adder_n.md
# pipelined_adder_n

- Parametrised, pipelined add/subtract unit with a valid/ready handshake on input and output.
- Each pipeline stage adds one WIDTH/STAGES-bit chunk of the operands. The carry is registered between stages, so the operating frequency scales with chunk width rather than full width.
- Sits in the datapath library as the successor to the fixed 4-bit combinational adder, for any block that needs wide addition, subtraction, carry and signed overflow at full throughput.

## Interface
Parameters:
- WIDTH, 16, operand and result width in bits; must be ≥ 2.
- STAGES, 4, number of pipeline stages; WIDTH % STAGES must be 0. CHUNK = WIDTH/STAGES.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and mode are valid this cycle.
- in_ready  output  1  unit accepts input this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A−B.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. For subtraction, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.

## Operation
- Subtraction is computed as A + ~B + 1: the stage-0 carry-in equals sub, and B is inverted when sub=1.
- Stage k (0..STAGES−1):
  - Adds bits [k·CHUNK +: CHUNK] of A and B', plus the carry registered from stage k−1.
  - Registers the partial sum, the carry, and the still-unused higher operand chunks.
- Lower result chunks are carried forward unchanged, so sum is aligned at the last stage.
- overflow = carry into MSB XOR carry out of MSB, evaluated in the last stage.
- Each stage has its own valid bit. Stage 0 loads in_valid; stage k loads stage k−1's valid bit.
- Global stall: advance = !out_valid || out_ready.
  - When advance=1, every stage register loads from its predecessor, and bubbles move with the data.
  - When advance=0, all stages hold.
  - Bubbles are not collapsed.
- in_ready = advance. This is a combinational path from out_ready to in_ready and is intentional.
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Results leave strictly in acceptance order. None is dropped or duplicated.
- sum, cout and overflow are registered outputs. They are meaningful only while out_valid=1 and hold their value while stalled.

## Timing
- Reset (rst_n=0, asynchronous): all valid bits clear and all data registers clear. Outputs: out_valid=0, sum=0, cout=0, overflow=0. in_ready=1 (since out_valid=0).
- Reset mid-operation: every in-flight transaction is discarded immediately. The first transfer after rst_n deasserts is processed normally.
- Latency: an input accepted at edge n appears with out_valid=1 after edge n+STAGES−1, provided there is no stall.
- Throughput: one result per cycle while out_ready=1.
- A stall of S cycles (out_valid=1, out_ready=0) delays every in-flight result by exactly S cycles.
- Input and output transfers in the same cycle are both taken. Occupancy stays constant.
- STAGES=1 degenerates to a single registered adder with a latency of one edge.

## Configuration
- ADDER_SAT_EN defined: when overflow=1, sum saturates to the signed extreme.
  - Positive overflow gives 0x7FF…F; negative overflow gives 0x800…0.
  - cout and overflow are still reported unmodified.
- ADDER_SAT_EN undefined: sum wraps modulo 2^WIDTH. No saturation logic is built.

## Test plan
All scenarios use WIDTH=16, STAGES=4, out_ready=1 unless stated.
- a=0x00FF, b=0x0001, sub=0 -> sum=0x0100, cout=0, overflow=0, out_valid 4 cycles after acceptance. This exercises carry across chunk boundaries.
- a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, cout=1, overflow=0.
- a=0x7FFF, b=0x0001, sub=0 -> overflow=1, cout=0. sum=0x8000 without ADDER_SAT_EN, 0x7FFF with it.
- sub=1 cases:
  - a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, overflow=0.
  - a=0x8000, b=0x0001 -> overflow=1, cout=1. sum=0x7FFF without ADDER_SAT_EN, 0x8000 with it.
- Eight back-to-back inputs a=i, b=i (i=1..8), with out_ready=0 for 3 cycles after the first output -> in_ready=0 for those 3 cycles, results 2,4,…,16 in order, none lost or duplicated.
- rst_n pulsed low with 3 transactions in flight -> out_valid falls immediately, sum=0, no stale result appears afterwards, and the next transaction (a=0x1234, b=0x1111) yields 0x2345.
